// File: rtl/lsu_memory.sv
// lsu_memory: byte-addressed 32-bit data memory with RISC-V load/store sizing and a fixed response latency
module lsu_memory #(
  parameter int WORDS = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] mem [WORDS];
  logic [31:0] word, ld_data, wr_data, res_rdata, pend_rdata;
  logic [15:0] ld_h;
  logic [7:0] ld_b;
  logic [3:0] be;
  logic [AW-1:0] idx;
  logic acc, in_range, code_ok, aligned, legal, res_err, pend_err;
  assign req_ready = rst_n && state == IDLE;
  assign rsp_valid = state == RESP;
  assign acc = req_valid && req_ready;
  assign idx = req_addr[AW+1:2];
  assign in_range = req_addr[31:2] < 30'(WORDS);
  assign code_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(req_we && req_funct3[2]);
  assign aligned = req_funct3[1:0] == 2'b10 ? req_addr[1:0] == 2'b00 : req_funct3[0] ? !req_addr[0] : 1'b1;
  assign legal = in_range && code_ok && aligned;
  assign word = mem[idx];
  assign ld_b = 8'(word >> {req_addr[1:0], 3'b000});
  assign ld_h = 16'(word >> {req_addr[1], 4'b0000});
  assign ld_data = req_funct3 == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
                   req_funct3 == 3'b100 ? {24'b0, ld_b} :
                   req_funct3 == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
                   req_funct3 == 3'b101 ? {16'b0, ld_h} : word;
  assign res_rdata = legal && !req_we ? ld_data : 32'b0;
  assign res_err = !legal;
  assign be = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
              req_funct3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wr_data = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                   req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  always_comb begin
    state_n = state == IDLE ? (acc ? (LATENCY == 1 ? RESP : BUSY) : IDLE) :
              state == BUSY ? (cnt == '0 ? RESP : BUSY) : IDLE;
  end
  // The result is computed at accept; it reaches the response registers on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend_rdata <= '0;
      pend_err <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        cnt <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
        pend_rdata <= res_rdata;
        pend_err <= res_err;
      end else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (acc && legal && req_we)
        for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      if (state_n == RESP && state != RESP) begin
        rsp_rdata <= acc ? res_rdata : pend_rdata;
        rsp_err <= acc ? res_err : pend_err;
      end
    end
  end
endmodule

// File: tb/tb_lsu_memory.sv
// tb_lsu_memory: randomized scoreboard bench for lsu_memory against a byte-array reference model
module tb_lsu_memory;
  localparam int WORDS = 16;
  localparam int LAT = 3;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  typedef struct {logic [31:0] rdata; logic err; int acc;} exp_t;
  exp_t q[$];
  logic [7:0] mm [4*WORDS];
  int cyc = 0, checks = 0, errors = 0, rsp_cnt = 0;
  logic prev_v = 0;

  lsu_memory #(.WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4*WORDS; i++) mm[i] = 8'h00;
  endfunction

  // Reference: access size n bytes, legality from the decode rules, memory as a flat byte array.
  function automatic logic [32:0] model(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int n;
    logic [31:0] v;
    bit legal;
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && f3[2]) && (a % n == 0) && (a / 4 < WORDS);
    if (!legal) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < n; i++) mm[a + i] = wd[8*i +: 8];
      return 33'h0;
    end
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a + i];
    if (!f3[2]) for (int i = 8*n; i < 32; i++) v[i] = v[8*n-1];
    return {1'b0, v};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      chk("rsp_single_pulse", {31'b0, prev_v}, 32'd0);
      chk("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response pending");
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_latency", 32'(cyc - e.acc), 32'(LAT - 1));
      end
    end
    prev_v = rsp_valid === 1'b1;
  end

  task automatic issue(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, output int acc);
    int t;
    logic [32:0] r;
    exp_t e;
    t = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (req_ready !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        req_valid = 0;
        acc = -1;
        return;
      end
    end
    r = model(we, f3, a, wd);
    acc = cyc + 1;
    e.rdata = r[31:0]; e.err = r[32]; e.acc = acc;
    q.push_back(e);
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic op(string name, logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] er, logic ee);
    int acc;
    issue(we, f3, a, wd, acc);
    drain();
    chk({name, "_rdata"}, rsp_rdata, er);
    chk({name, "_err"}, {31'b0, rsp_err}, {31'b0, ee});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a1, a2, n0;
    model_clear();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("ready_in_reset", {31'b0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);
    op("s1_sw", 1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 0);
    op("s1_lw", 0, 3'b010, 32'h8, 32'h0, 32'hDEADBEEF, 0);
    op("s2_sb", 1, 3'b000, 32'h9, 32'h000000A5, 32'h0, 0);
    op("s2_lw", 0, 3'b010, 32'h8, 32'h0, 32'hDEADA5EF, 0);
    op("s2_lb", 0, 3'b000, 32'h9, 32'h0, 32'hFFFFFFA5, 0);
    op("s2_lbu", 0, 3'b100, 32'h9, 32'h0, 32'h000000A5, 0);
    op("s2_lh", 0, 3'b001, 32'hA, 32'h0, 32'hFFFFDEAD, 0);
    op("s3_sw_mis", 1, 3'b010, 32'h6, 32'h12345678, 32'h0, 1);
    op("s3_lh_mis", 0, 3'b001, 32'h9, 32'h0, 32'h0, 1);
    op("s3_lw4", 0, 3'b010, 32'h4, 32'h0, 32'h0, 0);
    op("s4_lw_oor", 0, 3'b010, 32'(4*WORDS), 32'h0, 32'h0, 1);
    op("s4_f3_011", 0, 3'b011, 32'h8, 32'h0, 32'h0, 1);
    op("s4_sbu", 1, 3'b100, 32'h8, 32'h00000011, 32'h0, 1);
    op("s4_lw_keep", 0, 3'b010, 32'h8, 32'h0, 32'hDEADA5EF, 0);
    n0 = rsp_cnt;
    issue(0, 3'b010, 32'h8, 32'h0, a1);
    issue(0, 3'b001, 32'hA, 32'h0, a2);
    chk("s5_second_accept", 32'(a2 - a1), 32'(LAT + 1));
    drain();
    chk("s5_two_pulses", 32'(rsp_cnt - n0), 32'd2);
    issue(0, 3'b010, 32'h8, 32'h0, a1);
    rst_n = 0;
    q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("s6_ready_after_reset", {31'b0, req_ready}, 32'd1);
    n0 = rsp_cnt;
    repeat (2*LAT + 2) @(negedge clk);
    chk("s6_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    op("s6_lw", 0, 3'b010, 32'h8, 32'h0, 32'h0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 15) == 0 ? $urandom : 32'($urandom_range(0, 4*WORDS + 7));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, a1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
